demo_launch_ctrl: RTL and testbench
===================================

# demo_launch_ctrl

Parametrised launch/sequencing controller for bus demo systems with NUM_MASTERS demo masters. It converts a debounced active-low pushbutton press into per-master start pulses, either simultaneous or staggered, and tracks completion through each master's ready line. It also supports single-shot or continuous repeat rounds, counts completed rounds and flags hung transfers with a timeout. It sits between board-level buttons/switches and the demo_master instances, in front of the bus.

## Interface
- NUM_MASTERS, 2: number of controlled masters (>=1).
- DEBOUNCE_CYCLES, 4: consecutive low samples of start needed for a press (>=1).
- STAGGER_CYCLES, 8: spacing between launches in staggered mode (>=1).
- TIMEOUT_CYCLES, 1024: maximum WAIT cycles per round (>=1).
- CNT_WIDTH, 8: width of round counter.

- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- start  in  1  pushbutton, active-low (press = low).
- en  in  NUM_MASTERS  per-master enable.
- mode_in  in  NUM_MASTERS  per-master mode: 0 read, 1 write.
- repeat_mode  in  1  0 single round, 1 continuous rounds.
- stagger  in  1  0 simultaneous launch, 1 staggered launch.
- m_ready  in  NUM_MASTERS  ready from each master.
- m_start  out  NUM_MASTERS  one-cycle start pulse per master.
- m_mode  out  NUM_MASTERS  latched mode per master.
- busy  out  1  high in LAUNCH/WAIT.
- done  out  1  one-cycle pulse per completed round.
- timeout  out  1  sticky hang flag.
- round_count  out  CNT_WIDTH  completed rounds, wraps modulo 2^CNT_WIDTH.

## Operation
- Reset values: m_start=0, m_mode=0, busy=0, done=0, timeout=0, round_count=0, state IDLE, low_cnt=0, armed=1, stop_req=0, pending=0.
- Debounce: while armed, low_cnt increments on each edge sampling start=0. At the edge it reaches DEBOUNCE_CYCLES, a press event fires and armed clears. Any high sample zeroes low_cnt and sets armed. A button held low after reset yields one press.
- IDLE:
  - Press is accepted only if en!=0 and (m_ready & en)==en.
  - On acceptance: latch active=en and m_mode=mode_in, clear timeout, idx=0, gap=0, go LAUNCH.
  - A rejected press is dropped; armed still clears.
- LAUNCH, simultaneous: at the next edge, m_start<=active for one cycle, pending<=active, go WAIT.
- LAUNCH, staggered: evaluated per edge, with gap counting down to 0.
  - If gap==0 and active[idx]=1: pulse m_start[idx], set pending[idx], load gap=STAGGER_CYCLES-1, advance idx.
  - If gap==0 and active[idx]=0: advance idx, costing one cycle.
  - After idx NUM_MASTERS-1 is handled: go WAIT.
- Completion: in LAUNCH or WAIT, pending[k] clears at an edge seeing m_ready[k]=1 with the previous sample 0, provided pending[k] was already set.
- WAIT:
  - Timeout counter zeroed on entry.
  - When pending==0: done=1 for one cycle, round_count+1. Next state is LAUNCH (idx=0, gap=0, same active/m_mode) if repeat_mode=1 and stop_req=0, else IDLE.
  - When the counter reaches TIMEOUT_CYCLES with pending!=0: timeout=1, pending=0, go IDLE. No done pulse, no count.
- Press while busy: sets stop_req if repeat_mode=1, otherwise ignored. stop_req clears on entering IDLE.
- rstn low mid-round returns all state to reset values at that edge. m_start is never asserted in the reset cycle.

## Timing
- First low sample of start at edge E; the press registers at edge E+DEBOUNCE_CYCLES-1, and IDLE->LAUNCH happens at that edge.
- Simultaneous mode: m_start is high for the cycle after edge E+DEBOUNCE_CYCLES.
- Staggered mode: consecutive active masters launch exactly STAGGER_CYCLES edges apart, plus one edge per skipped inactive index between them.
- done follows the pending-clearing edge by one edge. A repeat relaunch adds one LAUNCH edge before m_start.
- busy is a decode of state: high from the IDLE->LAUNCH edge until the edge returning to IDLE.

## Test plan
- NUM_MASTERS=2, D=4, en=11, stagger=0; start low 4 cycles with both ready -> m_start=11 for one cycle, 5 edges after the first low sample. Masters ready-pulse -> done, round_count=1.
- Staggered mode, STAGGER_CYCLES=8, en=11 -> m_start[0] then m_start[1] 8 cycles later. With en=10 -> only m_start[1], 1 cycle after LAUNCH entry.
- Bounce: start low 3 cycles, high 1, low 3 -> no press. Held low 20 cycles -> exactly one press.
- Press with en=11, m_ready=01 -> ignored; busy stays 0. Press with en=00 -> ignored.
- Master 1 never returns ready, TIMEOUT_CYCLES=16 -> timeout=1 after 16 WAIT cycles, IDLE, round_count unchanged. Next accepted press clears timeout.
- repeat_mode=1 -> round_count increments each round. Press mid-round -> that round finishes with done, then IDLE. rstn low mid-WAIT -> all outputs 0.

Source files
------------

// File: rtl/demo_launch_ctrl.sv
// demo_launch_ctrl
//   Turns a debounced active-low pushbutton into start pulses for a set of
//   demo masters, launched either together or staggered, and tracks each
//   master's ready line to detect round completion. Supports single or
//   continuous rounds, counts completed rounds and flags hung rounds.
//
// Ports
//   clk          clock, rising edge
//   rstn         synchronous active-low reset
//   start        pushbutton, active-low
//   en           per-master enable
//   mode_in      per-master mode (0 read, 1 write)
//   repeat_mode  0 single round, 1 continuous rounds
//   stagger      0 simultaneous launch, 1 staggered launch
//   m_ready      ready line from each master
//   m_start      one-cycle start pulse per master
//   m_mode       mode latched at round acceptance
//   busy         high while a round is launching or in flight
//   done         one-cycle pulse per completed round
//   timeout      sticky hang flag, cleared by the next accepted press
//   round_count  completed rounds, wraps
module demo_launch_ctrl #(
    parameter int NUM_MASTERS     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STAGGER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [NUM_MASTERS-1:0] en,
    input  logic [NUM_MASTERS-1:0] mode_in,
    input  logic                   repeat_mode,
    input  logic                   stagger,
    input  logic [NUM_MASTERS-1:0] m_ready,
    output logic [NUM_MASTERS-1:0] m_start,
    output logic [NUM_MASTERS-1:0] m_mode,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [CNT_WIDTH-1:0]   round_count
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int GW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam int LW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(STAGGER_CYCLES - 1);
    localparam logic [LW-1:0] PRESS_AT = LW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT
    } state_t;

    // ---------------------------------------------------------------
    // Debounce: the press fires combinationally on the edge where the
    // low-sample count reaches DEBOUNCE_CYCLES, then disarms until a
    // high sample is seen.
    // ---------------------------------------------------------------
    logic [LW-1:0] low_cnt;
    logic          armed;
    logic          press;

    assign press = armed && !start && (low_cnt == PRESS_AT);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            low_cnt <= '0;
            armed   <= 1'b1;
        end else if (start) begin
            low_cnt <= '0;
            armed   <= 1'b1;
        end else if (armed) begin
            if (press) begin
                low_cnt <= '0;
                armed   <= 1'b0;
            end else begin
                low_cnt <= low_cnt + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Ready edge detection
    // ---------------------------------------------------------------
    logic [NUM_MASTERS-1:0] ready_q;
    logic [NUM_MASTERS-1:0] rise;

    assign rise = m_ready & ~ready_q;

    // ---------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------
    state_t                 state, state_n;
    logic [NUM_MASTERS-1:0] active, active_n;
    logic [NUM_MASTERS-1:0] pending, pending_n;
    logic [NUM_MASTERS-1:0] mode_n, start_n;
    logic [IW-1:0]          idx, idx_n;
    logic [GW-1:0]          gap, gap_n;
    logic [TW-1:0]          tcnt, tcnt_n;
    logic                   stop_req, stop_n;
    logic                   done_n, timeout_n;
    logic [CNT_WIDTH-1:0]   count_n;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            active      <= '0;
            pending     <= '0;
            idx         <= '0;
            gap         <= '0;
            tcnt        <= '0;
            stop_req    <= 1'b0;
            m_start     <= '0;
            m_mode      <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            round_count <= '0;
            ready_q     <= '0;
        end else begin
            state       <= state_n;
            active      <= active_n;
            pending     <= pending_n;
            idx         <= idx_n;
            gap         <= gap_n;
            tcnt        <= tcnt_n;
            stop_req    <= stop_n;
            m_start     <= start_n;
            m_mode      <= mode_n;
            done        <= done_n;
            timeout     <= timeout_n;
            round_count <= count_n;
            ready_q     <= m_ready;
        end
    end

    always_comb begin
        state_n   = state;
        active_n  = active;
        pending_n = pending;
        mode_n    = m_mode;
        idx_n     = idx;
        gap_n     = gap;
        tcnt_n    = tcnt;
        stop_n    = stop_req;
        start_n   = '0;
        done_n    = 1'b0;
        timeout_n = timeout;
        count_n   = round_count;

        case (state)
            ST_IDLE: begin
                if (press && (en != '0) && ((m_ready & en) == en)) begin
                    active_n  = en;
                    mode_n    = mode_in;
                    timeout_n = 1'b0;
                    idx_n     = '0;
                    gap_n     = '0;
                    state_n   = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                // Clear before set so a master launched this edge stays pending.
                pending_n = pending & ~rise;
                tcnt_n    = '0;
                if (!stagger) begin
                    start_n   = active;
                    pending_n = pending_n | active;
                    state_n   = ST_WAIT;
                end else if (gap != '0) begin
                    gap_n = gap - 1'b1;
                end else begin
                    if (active[idx]) begin
                        start_n[idx]   = 1'b1;
                        pending_n[idx] = 1'b1;
                        gap_n          = GAP_LOAD;
                    end
                    idx_n = idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state_n = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                pending_n = pending & ~rise;
                if (pending == '0) begin
                    done_n  = 1'b1;
                    count_n = round_count + 1'b1;
                    if (repeat_mode && !stop_req) begin
                        idx_n   = '0;
                        gap_n   = '0;
                        state_n = ST_LAUNCH;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (tcnt == TO_LAST) begin
                    timeout_n = 1'b1;
                    pending_n = '0;
                    state_n   = ST_IDLE;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (press && (state != ST_IDLE) && repeat_mode) begin
            stop_n = 1'b1;
        end
        // Entering (or staying in) IDLE always drops a pending stop.
        if (state_n == ST_IDLE) begin
            stop_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_demo_launch_ctrl.sv
// tb_demo_launch_ctrl
//   Directed bench for demo_launch_ctrl with a behavioural master model.
//   Expected m_start/done events (cycle and value) are queued when a press
//   is driven and matched against the events recorded from the DUT.
module tb_demo_launch_ctrl;

    localparam int LAT = 2;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [1:0] en;
    logic [1:0] mode_in;
    logic       repeat_mode;
    logic       stagger;
    logic [1:0] m_ready;
    logic [1:0] m_start;
    logic [1:0] m_mode;
    logic       busy;
    logic       done;
    logic       timeout;
    logic [7:0] round_count;

    logic [1:0]  rdy = 2'b11;
    logic [1:0]  ovr;
    logic        ovr_en;
    logic [1:0]  hang;
    int unsigned bcnt [2] = '{0, 0};
    int unsigned cyc = 0;

    ev_t exp_s[$];
    ev_t exp_d[$];
    ev_t obs_s[$];
    ev_t obs_d[$];
    ev_t me;
    int unsigned es_rd = 0, os_rd = 0, ed_rd = 0, od_rd = 0;
    int unsigned n_chk = 0, n_fail = 0;
    int unsigned c;
    logic [7:0]  rc;

    assign m_ready = ovr_en ? ovr : rdy;

    demo_launch_ctrl #(
        .NUM_MASTERS     (2),
        .DEBOUNCE_CYCLES (4),
        .STAGGER_CYCLES  (8),
        .TIMEOUT_CYCLES  (16),
        .CNT_WIDTH       (8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .en          (en),
        .mode_in     (mode_in),
        .repeat_mode (repeat_mode),
        .stagger     (stagger),
        .m_ready     (m_ready),
        .m_start     (m_start),
        .m_mode      (m_mode),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .round_count (round_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder and master model: a master drops ready when started
    // and raises it LAT+1 negedges later unless hung.
    always @(negedge clk) begin
        if (m_start != 2'b00) begin
            me.cyc = cyc;
            me.val = {6'b0, m_start};
            obs_s.push_back(me);
        end
        if (done) begin
            me.cyc = cyc;
            me.val = round_count;
            obs_d.push_back(me);
        end
        for (int k = 0; k < 2; k++) begin
            if (m_start[k]) begin
                rdy[k]  = 1'b0;
                bcnt[k] = LAT;
            end else if (!rdy[k] && !hang[k]) begin
                if (bcnt[k] == 0) rdy[k] = 1'b1;
                else bcnt[k] = bcnt[k] - 1;
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_start(input int unsigned cy, input logic [1:0] v);
        ev_t e;
        e.cyc = cy;
        e.val = {6'b0, v};
        exp_s.push_back(e);
    endtask

    task automatic push_done(input int unsigned cy, input logic [7:0] v);
        ev_t e;
        e.cyc = cy;
        e.val = v;
        exp_d.push_back(e);
    endtask

    task automatic drain();
        while (es_rd < exp_s.size()) begin
            if (os_rd < obs_s.size()) begin
                chk("m_start_cycle", obs_s[os_rd].cyc, exp_s[es_rd].cyc);
                chk("m_start_value", obs_s[os_rd].val, exp_s[es_rd].val);
                os_rd++;
            end else begin
                chk("m_start_missing", obs_s.size(), es_rd + 1);
            end
            es_rd++;
        end
        while (os_rd < obs_s.size()) begin
            chk("m_start_unexpected", obs_s.size(), exp_s.size());
            os_rd++;
        end
        while (ed_rd < exp_d.size()) begin
            if (od_rd < obs_d.size()) begin
                chk("done_cycle", obs_d[od_rd].cyc, exp_d[ed_rd].cyc);
                chk("done_count", obs_d[od_rd].val, exp_d[ed_rd].val);
                od_rd++;
            end else begin
                chk("done_missing", obs_d.size(), ed_rd + 1);
            end
            ed_rd++;
        end
        while (od_rd < obs_d.size()) begin
            chk("done_unexpected", obs_d.size(), exp_d.size());
            od_rd++;
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b1; en = 2'b11; mode_in = 2'b00;
        repeat_mode = 1'b0; stagger = 1'b0; ovr = 2'b11; ovr_en = 1'b0; hang = 2'b00;
        rc = 8'd0;

        // Reset state
        step(3);
        chk("rst_m_start", m_start, 2'b00);
        chk("rst_m_mode", m_mode, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_round_count", round_count, 8'd0);
        rstn = 1'b1;
        step(2);

        // Simultaneous launch, button held low 20 cycles -> one round
        mode_in = 2'b10;
        c = cyc; start = 1'b0;
        push_start(c + 5, 2'b11);
        push_done(c + 10, rc + 8'd1);
        rc = rc + 8'd1;
        step(3);
        chk("press_latency_busy_low", busy, 1'b0);
        step(1);
        chk("press_busy_high", busy, 1'b1);
        chk("mode_latched", m_mode, 2'b10);
        mode_in = 2'b01;
        step(16);
        start = 1'b1;
        chk("mode_held", m_mode, 2'b10);
        chk("count_after_held", round_count, rc);
        chk("idle_after_round", busy, 1'b0);
        step(4);
        drain();

        // Staggered launch, both enabled
        stagger = 1'b1;
        c = cyc; start = 1'b0;
        push_start(c + 5, 2'b01);
        push_start(c + 13, 2'b10);
        push_done(c + 18, rc + 8'd1);
        rc = rc + 8'd1;
        step(6); start = 1'b1;
        step(20);
        drain();

        // Staggered launch, only master 1 enabled
        en = 2'b10;
        c = cyc; start = 1'b0;
        push_start(c + 6, 2'b10);
        push_done(c + 11, rc + 8'd1);
        rc = rc + 8'd1;
        step(6); start = 1'b1;
        step(10);
        drain();
        stagger = 1'b0; en = 2'b11;

        // Bounce: 3 low, 1 high, 3 low -> no press
        start = 1'b0; step(3);
        start = 1'b1; step(1);
        start = 1'b0; step(3);
        start = 1'b1; step(6);
        chk("bounce_busy", busy, 1'b0);
        chk("bounce_count", round_count, rc);
        drain();

        // Rejected presses: a master not ready, and nothing enabled
        ovr_en = 1'b1; ovr = 2'b01;
        start = 1'b0; step(6);
        chk("reject_not_ready", busy, 1'b0);
        start = 1'b1; step(2);
        ovr_en = 1'b0;
        en = 2'b00;
        start = 1'b0; step(6);
        chk("reject_no_enable", busy, 1'b0);
        start = 1'b1; step(2);
        en = 2'b11;
        drain();
        chk("reject_count", round_count, rc);

        // Timeout: master 1 never returns ready
        hang = 2'b10;
        c = cyc; start = 1'b0;
        push_start(c + 5, 2'b11);
        step(6); start = 1'b1;
        step(14);
        chk("timeout_not_yet", timeout, 1'b0);
        chk("timeout_busy_before", busy, 1'b1);
        step(1);
        chk("timeout_set", timeout, 1'b1);
        chk("timeout_idle", busy, 1'b0);
        chk("timeout_count", round_count, rc);
        start = 1'b0; step(6);
        chk("hung_reject_busy", busy, 1'b0);
        chk("timeout_sticky", timeout, 1'b1);
        start = 1'b1; step(2);
        hang = 2'b00;
        step(5);
        c = cyc; start = 1'b0;
        push_start(c + 5, 2'b11);
        push_done(c + 10, rc + 8'd1);
        rc = rc + 8'd1;
        step(4);
        chk("timeout_cleared", timeout, 1'b0);
        chk("relaunch_busy", busy, 1'b1);
        step(2); start = 1'b1;
        step(10);
        drain();

        // Continuous rounds, stopped by a press mid-round
        repeat_mode = 1'b1;
        c = cyc; start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_start(c + 5 + 6 * k, 2'b11);
            push_done(c + 10 + 6 * k, rc + 8'(k + 1));
        end
        step(6); start = 1'b1;
        step(14); start = 1'b0;
        step(6); start = 1'b1;
        step(3);
        chk("repeat_stopped", busy, 1'b0);
        rc = rc + 8'd4;
        chk("repeat_count", round_count, rc);
        repeat_mode = 1'b0;
        step(6);
        drain();

        // Reset in the middle of WAIT
        mode_in = 2'b11; hang = 2'b10;
        c = cyc; start = 1'b0;
        push_start(c + 5, 2'b11);
        step(6); start = 1'b1;
        step(2);
        chk("wait_busy", busy, 1'b1);
        chk("wait_mode", m_mode, 2'b11);
        rstn = 1'b0;
        step(1);
        chk("midrst_m_start", m_start, 2'b00);
        chk("midrst_m_mode", m_mode, 2'b00);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_timeout", timeout, 1'b0);
        chk("midrst_count", round_count, 8'd0);
        rstn = 1'b1; hang = 2'b00;
        rc = 8'd0;
        step(8);
        drain();

        // Recovery round after reset
        c = cyc; start = 1'b0;
        push_start(c + 5, 2'b11);
        push_done(c + 10, rc + 8'd1);
        rc = rc + 8'd1;
        step(6); start = 1'b1;
        step(10);
        drain();
        chk("final_count", round_count, rc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
